xpb_lut_bank: RTL

//  Runtime-loadable, pipelined XPB reduction-constant table. It holds 2^WIN_W entries of DATA_W bits.

---
 rtl/xpb_lut_bank.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/xpb_lut_bank.sv
// Runtime-loadable, pipelined XPB reduction-constant table with NUM_CH parallel lookup channels.
// Optional per-entry even parity is enabled by defining XPB_LUT_PARITY_EN.
module xpb_lut_bank #(
  parameter int WIN_W   = 5,
  parameter int DATA_W  = 1024,
  parameter int LOAD_W  = 64,
  parameter int NUM_CH  = 2,
  parameter int OUT_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  input  logic [LOAD_W-1:0]        ld_data,
  output logic                     ld_ready,
  output logic                     tbl_ready,
  input  logic [NUM_CH-1:0]        lk_valid,
  input  logic [NUM_CH*WIN_W-1:0]  lk_idx,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     lk_err,
  output logic [NUM_CH-1:0]        par_err
);

  localparam int DEPTH   = 1 << WIN_W;
  localparam int NCHUNK  = DATA_W / LOAD_W;
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NCHUNK - 1);
  localparam logic [WIN_W-1:0]   LAST_ENTRY = '1;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_e;

  state_e               state_q, state_d;
  logic [CHUNK_W-1:0]   chunk_q, chunk_d;
  logic [WIN_W-1:0]     entry_q, entry_d;
  logic                 beat_acc, last_beat, tbl_ok;
  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic [NUM_CH-1:0]              lk_hit;
  logic                           lk_err_q, lk_err_d;
  logic [NUM_CH-1:0]              s1_valid_q, s1_valid_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  s1_data_q, s1_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      chunk_q <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      entry_q <= entry_d;
    end
  end

  // ld_start takes priority over a same-cycle beat, so a restart never writes.
  always_comb begin
    beat_acc  = (state_q == LOAD) && ld_valid && !ld_start;
    last_beat = beat_acc && (chunk_q == LAST_CHUNK) && (entry_q == LAST_ENTRY);
    chunk_d   = chunk_q;
    entry_d   = entry_q;
    if (ld_start) begin
      chunk_d = '0;
      entry_d = WIN_W'(1);
    end else if (beat_acc) begin
      if (chunk_q == LAST_CHUNK) begin
        chunk_d = '0;
        entry_d = entry_q + 1'b1;
      end else begin
        chunk_d = chunk_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (ld_start) state_d = LOAD;
      LOAD:    if (last_beat) state_d = READY;
      READY:   if (ld_start) state_d = LOAD;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    ld_ready  = (state_q == LOAD);
    tbl_ready = (state_q == READY);
    tbl_ok    = (state_q == READY);
  end

  always_ff @(posedge clk) begin
    if (beat_acc) mem_q[entry_q][int'(chunk_q)*LOAD_W +: LOAD_W] <= ld_data;
  end

  // Stage 1 snapshots the entry, so a reload cannot disturb in-flight results.
  always_comb begin
    lk_hit     = lk_valid & {NUM_CH{tbl_ok}};
    lk_err_d   = |(lk_valid & ~lk_hit);
    s1_valid_d = lk_hit;
    s1_data_d  = s1_data_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (lk_hit[c]) begin
        if (lk_idx[c*WIN_W +: WIN_W] == '0) s1_data_d[c] = '0;
        else                                s1_data_d[c] = mem_q[lk_idx[c*WIN_W +: WIN_W]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_err_q   <= 1'b0;
      s1_valid_q <= '0;
      s1_data_q  <= '0;
    end else begin
      lk_err_q   <= lk_err_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  assign lk_err = lk_err_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [NUM_CH-1:0]             s2_valid_q, s2_valid_d;
      logic [NUM_CH-1:0][DATA_W-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (s1_valid_q[c]) s2_data_d[c] = s1_data_q[c];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_valid_q <= '0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign out_valid = s2_valid_q;
      assign out_data  = s2_data_q;
    end else begin : g_nooreg
      assign out_valid = s1_valid_q;
      assign out_data  = s1_data_q;
    end
  endgenerate

`ifdef XPB_LUT_PARITY_EN
  logic              par_mem_q [DEPTH];
  logic              par_acc_q, par_acc_d, beat_par;
  logic [NUM_CH-1:0] p1_q, p1_d, out_par;

  always_comb begin
    beat_par  = ((chunk_q == '0) ? 1'b0 : par_acc_q) ^ (^ld_data);
    par_acc_d = beat_acc ? beat_par : par_acc_q;
    p1_d      = p1_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (lk_hit[c]) begin
        if (lk_idx[c*WIN_W +: WIN_W] == '0) p1_d[c] = 1'b0;
        else                                p1_d[c] = par_mem_q[lk_idx[c*WIN_W +: WIN_W]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_acc && (chunk_q == LAST_CHUNK)) par_mem_q[entry_q] <= beat_par;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_acc_q <= 1'b0;
      p1_q      <= '0;
    end else begin
      par_acc_q <= par_acc_d;
      p1_q      <= p1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_preg
      logic [NUM_CH-1:0] p2_q, p2_d;
      always_comb begin
        p2_d = p2_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (s1_valid_q[c]) p2_d[c] = p1_q[c];
        end
      end
      always_ff @(posedge clk) begin
        if (!rst_n) p2_q <= '0;
        else        p2_q <= p2_d;
      end
      assign out_par = p2_q;
    end else begin : g_nopreg
      assign out_par = p1_q;
    end
  endgenerate

  always_comb begin
    par_err = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      par_err[c] = out_valid[c] & ((^out_data[c*DATA_W +: DATA_W]) ^ out_par[c]);
    end
  end
`else
  assign par_err = '0;
`endif

endmodule
